// File: rtl/axi_crossbar_pkg.sv
// axi_crossbar_pkg: shared arbiter mode constants, FSM encoding and clog2 helper
package axi_crossbar_pkg;

    localparam bit ARB_MODE_FIXED = 1'b0;
    localparam bit ARB_MODE_RR    = 1'b1;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/axi_crossbar_arb_pick.sv
// axi_crossbar_arb_pick: first set request at or above a one-hot pointer, wrapping
module axi_crossbar_arb_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] win;

    // Doubling the request vector lets one subtraction isolate the winner across the wrap
    always_comb begin
        dbl   = {req_i, req_i};
        win   = dbl & ~(dbl - {{N{1'b0}}, ptr_i});
        gnt_o = win[N-1:0] | win[2*N-1:N];
        any_o = |req_i;
        idx_o = '0;
        for (int i = 0; i < N; i++) if (gnt_o[i]) idx_o = IDX_W'(i);
    end

endmodule

// File: rtl/axi_crossbar_rr_arbiter.sv
// axi_crossbar_rr_arbiter: locking round-robin/fixed arbiter for crossbar address channels
module axi_crossbar_rr_arbiter
    import axi_crossbar_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter bit ROUND_ROBIN = ARB_MODE_RR,
    parameter int IDX_W       = clog2(NUM_REQ)
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [NUM_REQ-1:0] requests_i,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_vld_o
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               arb_en;

    axi_crossbar_arb_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (requests_i),
        .ptr_i (ptr_d),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Pointer moves just past the releasing master; the picker sees the new value the same cycle
    always_comb begin
        ptr_d = (state_q == ARB_LOCKED && release_i && ROUND_ROBIN)
              ? {grant_q[NUM_REQ-2:0], grant_q[NUM_REQ-1]} : ptr_q;
    end

    // Arbitrate when idle or on release; otherwise the grant stays frozen
    always_comb begin
        arb_en  = (state_q == ARB_IDLE) || release_i;
        state_d = arb_en ? (pick_any ? ARB_LOCKED : ARB_IDLE) : state_q;
        grant_d = arb_en ? pick_gnt : grant_q;
        idx_d   = arb_en ? pick_idx : idx_q;
    end

    // State, grant and pointer registers; reset dominates everything
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= NUM_REQ'(1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign grant_vld_o = (state_q == ARB_LOCKED);

endmodule
